// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_pkg
//  Description : Shared types and constants for the PS/2 host transmitter:
//                FSM state encoding, keyboard command/response bytes and the
//                odd-parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQUEST = 3'd2,
        ST_SEND    = 3'd3,
        ST_ACK     = 3'd4
    } ps2_tx_state_t;

    // Host-to-keyboard commands
    localparam logic [7:0] c_cmd_leds   = 8'hED;
    localparam logic [7:0] c_cmd_reset  = 8'hFF;
    localparam logic [7:0] c_cmd_enable = 8'hF4;

    // Keyboard responses
    localparam logic [7:0] c_rsp_ack    = 8'hFA;
    localparam logic [7:0] c_rsp_resend = 8'hFE;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage : ps2_host_tx_pkg
`default_nettype wire

// File: rtl/ps2_clock_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_clock_filter
//  Description : Shift-register debounce for the PS/2 clock line. Produces a
//                filtered level and a one-cycle pulse on each filtered 1->0
//                transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_clock_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    logic [FILTER-1:0] r_shift;
    logic              r_level;
    logic              r_fall;

    logic              w_all_high;
    logic              w_all_low;

    assign w_all_high = &r_shift;
    assign w_all_low  = ~|r_shift;

    // Sample the raw line every cycle; the level only moves once the whole
    // window agrees, so short glitches never reach the level or the fall flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shift <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_shift <= {r_shift[FILTER-2:0], line};
            if (w_all_high) begin
                r_level <= 1'b1;
            end else if (w_all_low) begin
                r_level <= 1'b0;
            end
            r_fall <= r_level & w_all_low;
        end
    end

    assign level = r_level;
    assign fall  = r_fall;

endmodule : ps2_clock_filter
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter. Inhibits the bus, issues a
//                request-to-send, shifts one byte plus odd parity and stop on
//                device clock falls, then checks the device acknowledge.
//                Drives the bus only through open-drain pull-low enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT = 2800,
    parameter int TIMEOUT = 56000,
    parameter int FILTER  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] ps2,
    output logic       ps2c_low,
    output logic       ps2d_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int c_count_max = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
    localparam int c_cw        = $clog2(c_count_max) + 1;

    localparam logic [c_cw-1:0] c_inhibit_last = c_cw'(INHIBIT - 1);
    localparam logic [c_cw-1:0] c_timeout_last = c_cw'(TIMEOUT - 1);

    ps2_tx_state_t     r_state;
    logic              r_ps2c_low;
    logic              r_ps2d_low;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [c_cw-1:0]   r_count;
    logic [3:0]        r_index;
    logic [7:0]        r_byte;
    logic              r_parity;
    logic              r_data_q;

    ps2_tx_state_t     w_state_n;
    logic              w_ps2c_low_n;
    logic              w_ps2d_low_n;
    logic              w_busy_n;
    logic              w_done_n;
    logic              w_error_n;
    logic [c_cw-1:0]   w_count_n;
    logic [3:0]        w_index_n;
    logic [7:0]        w_byte_n;
    logic              w_parity_n;

    logic              w_clk_level;
    logic              w_clk_fall;
    logic              w_fall;
    logic              w_in_transfer;

    ps2_clock_filter #(
        .FILTER (FILTER)
    ) u_clock_filter (
        .clock (clock),
        .reset (reset),
        .line  (ps2[0]),
        .level (w_clk_level),
        .fall  (w_clk_fall)
    );

    // A genuine fall always leaves the filtered level low; qualifying on it
    // keeps the transmitter from acting on anything but a settled low clock.
    assign w_fall        = w_clk_fall & ~w_clk_level;
    assign w_in_transfer = (r_state == ST_REQUEST) || (r_state == ST_SEND) ||
                           (r_state == ST_ACK);

    // Data line is registered once so it is stable when read at a fall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_data_q <= 1'b1;
        end else begin
            r_data_q <= ps2[1];
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ps2c_low <= 1'b0;
            r_ps2d_low <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_count    <= '0;
            r_index    <= 4'd0;
            r_byte     <= 8'd0;
            r_parity   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_ps2c_low <= w_ps2c_low_n;
            r_ps2d_low <= w_ps2d_low_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_error    <= w_error_n;
            r_count    <= w_count_n;
            r_index    <= w_index_n;
            r_byte     <= w_byte_n;
            r_parity   <= w_parity_n;
        end
    end

    // Next-state and next-output logic, with the transfer timeout overriding
    // any per-state action once the device has gone quiet too long.
    always_comb begin
        w_state_n    = r_state;
        w_ps2c_low_n = r_ps2c_low;
        w_ps2d_low_n = r_ps2d_low;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_error_n    = 1'b0;
        w_count_n    = r_count;
        w_index_n    = r_index;
        w_byte_n     = r_byte;
        w_parity_n   = r_parity;

        unique case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_byte_n     = tx_data;
                    w_parity_n   = odd_parity(tx_data);
                    w_busy_n     = 1'b1;
                    w_ps2c_low_n = 1'b1;
                    w_ps2d_low_n = 1'b0;
                    w_count_n    = '0;
                    w_state_n    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (r_count == c_inhibit_last) begin
                    // Start bit: data low while clock is still inhibited
                    w_ps2d_low_n = 1'b1;
                    w_count_n    = '0;
                    w_state_n    = ST_REQUEST;
                end else begin
                    w_count_n = r_count + 1'b1;
                end
            end

            ST_REQUEST: begin
                // Hand the clock to the device; start bit remains on data
                w_ps2c_low_n = 1'b0;
                w_index_n    = 4'd0;
                w_state_n    = ST_SEND;
            end

            ST_SEND: begin
                if (w_fall) begin
                    case (r_index)
                        4'd0, 4'd1, 4'd2, 4'd3,
                        4'd4, 4'd5, 4'd6, 4'd7: w_ps2d_low_n = ~r_byte[r_index[2:0]];
                        4'd8:                   w_ps2d_low_n = ~r_parity;
                        default:                w_ps2d_low_n = 1'b0;
                    endcase
                    w_index_n = r_index + 4'd1;
                    if (r_index == 4'd9) begin
                        w_state_n = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                if (w_fall) begin
                    w_done_n     = ~r_data_q;
                    w_error_n    = r_data_q;
                    w_busy_n     = 1'b0;
                    w_ps2c_low_n = 1'b0;
                    w_ps2d_low_n = 1'b0;
                    w_state_n    = ST_IDLE;
                end
            end

            default: begin
                w_ps2c_low_n = 1'b0;
                w_ps2d_low_n = 1'b0;
                w_busy_n     = 1'b0;
                w_state_n    = ST_IDLE;
            end
        endcase

        if (w_in_transfer) begin
            if (w_fall) begin
                w_count_n = '0;
            end else if (r_count == c_timeout_last) begin
                w_ps2c_low_n = 1'b0;
                w_ps2d_low_n = 1'b0;
                w_busy_n     = 1'b0;
                w_done_n     = 1'b0;
                w_error_n    = 1'b1;
                w_state_n    = ST_IDLE;
            end else begin
                w_count_n = r_count + 1'b1;
            end
        end
    end

    assign ps2c_low = r_ps2c_low;
    assign ps2d_low = r_ps2d_low;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule : ps2_host_tx
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//                on a wired-AND bus and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int P_INHIBIT = 100;
    localparam int P_TIMEOUT = 600;
    localparam int P_FILTER  = 8;
    localparam int HALF      = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] ps2;
    logic       ps2c_low;
    logic       ps2d_low;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       busy;
    logic       done;
    logic       error;

    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_err  = 0;

    // Open-drain bus: either side can pull a line low
    assign ps2 = {dev_data & ~ps2d_low, dev_clk & ~ps2c_low};

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT (P_INHIBIT),
        .TIMEOUT (P_TIMEOUT),
        .FILTER  (P_FILTER)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2      (ps2),
        .ps2c_low (ps2c_low),
        .ps2d_low (ps2d_low),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         mode;   // 0 plain, 1 clock glitch, 2 tx_valid poke, 3 reset mid-send
    } vec_t;

    vec_t vecs[9];

    // Pulse monitor: counts completions and checks pulse exclusivity/busy
    always @(negedge clock) begin
        if (reset) begin
            if (done)  n_done++;
            if (error) n_err++;
            if (done || error) begin
                n_cmp++;
                if (busy || (done && error)) begin
                    n_fail++;
                    $display("FAIL pulse_flags: busy=%0b done=%0b error=%0b, required busy=0 and only one pulse",
                             busy, done, error);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Frame as the device should see it on its rising edges: start, eight
    // data bits LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((int'(b) >> i) % 2) == 1;
        end
        f[9]  = ($countones(b) % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic run_frame(input logic [7:0] b, input bit ack, input int mode);
        int          d0;
        int          e0;
        int          inh;
        logic [10:0] seen;
        d0   = n_done;
        e0   = n_err;
        seen = '0;

        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);

        inh = 0;
        while (ps2c_low && inh < P_INHIBIT + 50) begin
            inh++;
            tick();
        end
        check("inhibit_len", 32'(inh >= P_INHIBIT && inh <= P_INHIBIT + 2), 32'd1);
        check("start_bit_drive", 32'(ps2d_low), 32'd1);

        repeat (HALF / 2) tick();
        seen[0] = ps2[1];

        for (int k = 0; k <= 10; k++) begin
            if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            if (mode == 3 && k == 4) begin
                repeat (15) tick();
                reset = 1'b0;
                tick();
                check("reset_ps2c_low", 32'(ps2c_low), 32'd0);
                check("reset_ps2d_low", 32'(ps2d_low), 32'd0);
                check("reset_busy", 32'(busy), 32'd0);
                reset    = 1'b1;
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                repeat (30) tick();
                check("reset_no_done", 32'(n_done - d0), 32'd0);
                check("reset_no_error", 32'(n_err - e0), 32'd0);
                return;
            end
            if (mode == 2 && k == 3) begin
                repeat (15) tick();
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                check("poke_busy", 32'(busy), 32'd1);
                repeat (HALF - 16) tick();
            end else begin
                repeat (HALF) tick();
            end
            if (k < 10) seen[k+1] = ps2[1];
            dev_clk = 1'b1;
            if (mode == 1 && k == 4) begin
                repeat (10) tick();
                dev_clk = 1'b0;
                repeat (3) tick();
                dev_clk = 1'b1;
                repeat (HALF - 13) tick();
            end else begin
                repeat (HALF) tick();
            end
        end
        dev_data = 1'b1;
        repeat (5) tick();

        check("frame_bits", 32'(seen), 32'(ref_frame(b)));
        check("done_count", 32'(n_done - d0), ack ? 32'd1 : 32'd0);
        check("error_count", 32'(n_err - e0), ack ? 32'd0 : 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        repeat (10) tick();
    endtask

    task automatic timeout_test();
        int d0;
        int e0;
        int cnt;
        d0 = n_done;
        e0 = n_err;
        @(negedge clock);
        tx_data  = c_cmd_enable;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        cnt = 0;
        while (!ps2d_low && cnt < P_INHIBIT + 50) begin
            cnt++;
            tick();
        end
        cnt = 0;
        while (!error && cnt < P_TIMEOUT + 50) begin
            cnt++;
            tick();
        end
        check("timeout_cycles", 32'(cnt), 32'(P_TIMEOUT));
        check("timeout_ps2c_low", 32'(ps2c_low), 32'd0);
        check("timeout_ps2d_low", 32'(ps2d_low), 32'd0);
        tick();
        check("timeout_error_count", 32'(n_err - e0), 32'd1);
        check("timeout_no_done", 32'(n_done - d0), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        repeat (10) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{c_cmd_leds,   1'b1, 0};
        vecs[1] = '{8'h01,        1'b1, 0};
        vecs[2] = '{8'h00,        1'b1, 0};
        vecs[3] = '{c_cmd_reset,  1'b1, 0};
        vecs[4] = '{c_cmd_enable, 1'b0, 0};
        vecs[5] = '{8'hA5,        1'b1, 1};
        vecs[6] = '{c_cmd_leds,   1'b1, 2};
        vecs[7] = '{8'h3C,        1'b1, 3};
        vecs[8] = '{c_cmd_enable, 1'b1, 0};

        reset = 1'b0;
        repeat (3) tick();
        check("rst_ps2c_low", 32'(ps2c_low), 32'd0);
        check("rst_ps2d_low", 32'(ps2d_low), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_error", 32'({done, error}), 32'd0);
        reset = 1'b1;
        repeat (20) tick();

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].data, vecs[v].ack, vecs[v].mode);
        end

        timeout_test();

        for (int r = 0; r < 6; r++) begin
            logic [7:0] rb;
            bit         ra;
            rb = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) != 0);
            run_frame(rb, ra, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ps2_host_tx
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example 0xED plus an LED mask, 0xFF reset, or 0xF4 enable. It shares the two-wire PS/2 bus with the existing keyboard receiver and drives the bus only through open-drain pull-low enables. It sits beside the keyboard receiver in the top level and asserts busy so that the receiver ignores bus activity during a transmission.

Parameters:
INHIBIT, 2800, clock cycles the clock line is held low before the request (100 us at 28 MHz).
TIMEOUT, 56000, maximum clock cycles allowed between consecutive device falling clock edges, and from request to the first edge (2 ms at 28 MHz).
FILTER, 8, length of the clock-line glitch filter shift register.

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-low
ps2  in  2  sampled bus: bit0 = PS/2 clock, bit1 = PS/2 data
ps2c_low  out  1  1 = pull the PS/2 clock line low; 0 = release it
ps2d_low  out  1  1 = pull the PS/2 data line low; 0 = release it
tx_data  in  8  byte to send
tx_valid  in  1  one-cycle start strobe
busy  out  1  high from acceptance of tx_valid until done or error
done  out  1  one-cycle pulse: device acknowledged
error  out  1  one-cycle pulse: timeout or missing acknowledge

Behaviour:
- Reset: synchronous, sampled on the rising edge of clock while reset=0. Forces state IDLE, ps2c_low=0, ps2d_low=0, busy=0, done=0, error=0, counters=0, filter register all ones.
- Reset mid-transfer releases both lines on the next edge. The device's own timeout recovers it.
- Clock filter:
  - Shift ps2[0] into a FILTER-bit register every cycle.
  - The filtered level goes to 1 when the register is all ones and to 0 when it is all zeros.
  - A fall is a filtered 1->0 transition, flagged for one cycle.
  - ps2[1] is registered once and used at the fall.
- IDLE:
  - tx_valid=1 latches tx_data and the odd parity bit (~^tx_data).
  - busy goes to 1 the next cycle; state goes to INHIBIT with ps2c_low=1.
  - tx_valid while busy=1 is ignored and is not queued.
- INHIBIT: count INHIBIT cycles, then set ps2d_low=1 (start bit = 0) and go to REQUEST.
- REQUEST:
  - Hold ps2d_low=1 for one further cycle, then release ps2c_low and go to SEND with bit index 0.
  - The timeout counter starts here.
- SEND, on each fall:
  - Index 0-7: ps2d_low = ~data[index].
  - Index 8: ps2d_low = ~parity.
  - Index 9: ps2d_low=0 (stop bit, line released).
  - The index increments on each fall; after index 9 the state goes to ACK.
  - The device samples data on its rising edge, so data changes only at falls.
- ACK:
  - At the next fall, registered data=0 produces done=1 for one cycle.
  - Registered data=1 produces error=1 for one cycle.
  - Either way the state returns to IDLE and busy=0 in the same cycle as the pulse.
- Timeout:
  - In REQUEST, SEND or ACK, the timeout counter reloads on every fall.
  - If it reaches TIMEOUT, both lines are released, error pulses for one cycle, and the state returns to IDLE.
- done and error are never high together. busy is low in the cycle after the pulse, so a new tx_valid may be accepted in that cycle.
- Falls seen during IDLE or INHIBIT are ignored.
- Counter widths: $clog2(max(INHIBIT, TIMEOUT))+1 bits; the bit index is 4 bits.

Decomposition:
- Shared package holds:
  - state enum IDLE, INHIBIT, REQUEST, SEND, ACK;
  - PS/2 command constants CMD_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - response constants ACK=8'hFA, RESEND=8'hFE.
- One sub-module is natural: ps2_clock_filter (shift-register debounce producing the filtered level and a fall pulse). The keyboard receiver can later reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and acknowledging: ps2c_low stays high ≥2800 cycles; the bits seen on device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; one-cycle done pulse; busy falls in the same cycle.
- Send 0x01: data bits 1,0,0,0,0,0,0,0 and parity bit 0. Send 0x00: parity bit 1. Send 0xFF: parity bit 1.
- No device present (clock never falls after request): both lines released and error pulse exactly TIMEOUT cycles after REQUEST; done stays 0.
- Device withholds the acknowledge (data high at the 11th fall): error pulse, done=0, state back in IDLE.
- tx_valid pulsed again mid-SEND with 0x55: ignored; the original byte completes unchanged; only one done pulse.
- reset=0 asserted during SEND bit 4: on the next edge ps2c_low=0, ps2d_low=0 and busy=0; a following send of 0xF4 completes normally.
- 3-cycle glitch low on ps2[0] during SEND: no fall is detected and the bit index is unchanged.
